// File: rtl/fetch_stage_if.sv
// Signal bundle between the F stage, the D-stage decode/stall logic and instruction memory.
// FETCH_ADDR_CHECK_EN adds the address-fault outputs F_adel and fault_pc.
interface fetch_stage_if;
    logic        stall;
    logic        D_clr;
    logic [4:0]  D_NPCOp;
    logic        D_cmp_eq;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_data;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
`ifdef FETCH_ADDR_CHECK_EN
    logic        F_adel;
    logic [31:0] fault_pc;
`endif

    modport master (
        input  stall, D_clr, D_NPCOp, D_cmp_eq, D_imm16, D_imm26, D_rs_data, im_rdata,
        output im_addr, F_pc, D_instr, D_pc
`ifdef FETCH_ADDR_CHECK_EN
        , output F_adel, fault_pc
`endif
    );

    modport slave (
        output stall, D_clr, D_NPCOp, D_cmp_eq, D_imm16, D_imm26, D_rs_data, im_rdata,
        input  im_addr, F_pc, D_instr, D_pc
`ifdef FETCH_ADDR_CHECK_EN
        , input F_adel, fault_pc
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, next-PC select from D-stage decode, IF/ID register (delay-slot pipeline).
// Optional macro FETCH_ADDR_CHECK_EN enables fetch-address fault detection (F_adel, sticky fault_pc).
module fetch_stage #(
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_DEPTH) * 33'd4);

    logic [31:0] r_pc_p0;
    logic [31:0] r_instr_p1;
    logic [31:0] r_pc_p1;
    logic [31:0] w_npc;
    logic [31:0] w_fetch_word;

    function automatic logic [31:0] f_branch_target(input logic [31:0] pc, input logic [15:0] imm);
        logic signed [31:0] off;
        off = $signed({{14{imm[15]}}, imm, 2'b00});
        return pc + 32'd4 + $unsigned(off);
    endfunction

    function automatic logic f_fetch_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_END);
    endfunction

    // Targets are relative to D_pc (the branch); F_pc already holds the delay slot.
    always_comb begin
        w_npc = r_pc_p0 + 32'd4;
        case (bus.D_NPCOp)
            5'd1: if (bus.D_cmp_eq) w_npc = f_branch_target(r_pc_p1, bus.D_imm16);
            5'd2: w_npc = {r_pc_p1[31:28], bus.D_imm26, 2'b00};
            5'd3: w_npc = bus.D_rs_data;
            default: ;
        endcase
    end

`ifdef FETCH_ADDR_CHECK_EN
    logic        w_adel;
    logic        r_fault_seen;
    logic [31:0] r_fault_pc;

    assign w_adel       = f_fetch_fault(r_pc_p0);
    assign w_fetch_word = w_adel ? 32'h0 : bus.im_rdata;

    // Sticky capture of the first faulting fetch; a flag is needed because 0 is itself a faulting PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_seen <= 1'b0;
            r_fault_pc   <= 32'h0;
        end else if (!bus.stall && w_adel && !r_fault_seen) begin
            r_fault_seen <= 1'b1;
            r_fault_pc   <= r_pc_p0;
        end
    end

    assign bus.F_adel   = w_adel;
    assign bus.fault_pc = r_fault_pc;
`else
    assign w_fetch_word = bus.im_rdata;
`endif

    // p0 -> p1: PC advance and IF/ID capture; stall freezes both, D_clr only matters when not stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_p0    <= PC_INIT;
            r_instr_p1 <= 32'h0;
            r_pc_p1    <= PC_INIT;
        end else if (!bus.stall) begin
            r_pc_p0    <= w_npc;
            r_pc_p1    <= r_pc_p0;
            r_instr_p1 <= bus.D_clr ? 32'h0 : w_fetch_word;
        end
    end

    assign bus.im_addr = r_pc_p0;
    assign bus.F_pc    = r_pc_p0;
    assign bus.D_instr = r_instr_p1;
    assign bus.D_pc    = r_pc_p1;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, delay-slot/stall/fault sequences, randomized run vs a reference model.
module tb_fetch_stage;
    localparam logic [31:0] PC_INIT  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] mem [IM_DEPTH];

    fetch_stage_if bus();

    fetch_stage #(.PC_INIT(PC_INIT), .IM_BASE(IM_BASE), .IM_DEPTH(IM_DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(IM_BASE);
        if (off < 0 || off >= 4 * IM_DEPTH) return 32'hDEAD_BEEF;
        return mem[int'(off / 4)];
    endfunction

    always_comb bus.im_rdata = mem_rd(bus.im_addr);

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (longint'(a) < longint'(IM_BASE)) ||
               (longint'(a) >= longint'(IM_BASE) + 4 * IM_DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic c, input logic [4:0] op,
                         input logic cmp, input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rs);
        reset         = r;
        bus.stall     = s;
        bus.D_clr     = c;
        bus.D_NPCOp   = op;
        bus.D_cmp_eq  = cmp;
        bus.D_imm16   = i16;
        bus.D_imm26   = i26;
        bus.D_rs_data = rs;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, s, c;
        logic [4:0]  op;
        logic        cmp;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] f, di, dp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic c, input logic [4:0] op,
                       input logic cmp, input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] rs, input logic [31:0] f, input logic [31:0] di,
                       input logic [31:0] dp);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.op = op; v.cmp = cmp; v.i16 = i16; v.i26 = i26; v.rs = rs;
        v.f = f; v.di = di; v.dp = dp;
        tbl.push_back(v);
    endtask

    // Reference model state
    logic [31:0] m_f, m_di, m_dp;
`ifdef FETCH_ADDR_CHECK_EN
    logic [31:0] m_fpc;
    logic        m_seen;
`endif

    task automatic model_step();
        logic [31:0] npc;
        int          sx;
        if (reset) begin
            m_f = PC_INIT; m_di = 32'h0; m_dp = PC_INIT;
`ifdef FETCH_ADDR_CHECK_EN
            m_fpc = 32'h0; m_seen = 1'b0;
`endif
            return;
        end
        if (bus.stall) return;
        npc = m_f + 32'd4;
        if (bus.D_NPCOp == 5'd1 && bus.D_cmp_eq) begin
            sx  = $signed(bus.D_imm16);
            npc = m_dp + 32'd4 + 32'(sx * 4);
        end else if (bus.D_NPCOp == 5'd2) begin
            npc = (m_dp & 32'hF000_0000) | (32'(bus.D_imm26) * 32'd4);
        end else if (bus.D_NPCOp == 5'd3) begin
            npc = bus.D_rs_data;
        end
        m_di = bus.D_clr ? 32'h0 : mem_rd(m_f);
`ifdef FETCH_ADDR_CHECK_EN
        if (addr_bad(m_f)) begin
            if (!bus.D_clr) m_di = 32'h0;
            if (!m_seen) begin m_fpc = m_f; m_seen = 1'b1; end
        end
`endif
        m_dp = m_f;
        m_f  = npc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(I, O, O, 5'd0, O, 16'h0, 26'h0, 32'h0);
        for (int i = 0; i < IM_DEPTH; i++) mem[i] = 32'hC000_0000 | (IM_BASE + 32'(4 * i));

        //  r  s  c  op    cmp i16       i26        rs            F_pc          D_instr       D_pc
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3008, 32'hC000_3004, 32'h3004);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd1, I, 16'h0003, 26'h0,     32'h0,        32'h3010, 32'hC000_3004, 32'h3004);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3014, 32'hC000_3010, 32'h3010);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3008, 32'hC000_3004, 32'h3004);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h300C, 32'hC000_3008, 32'h3008);
        add(O, O, O, 5'd1, I, 16'hFFFF, 26'h0,     32'h0,        32'h3008, 32'hC000_300C, 32'h300C);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h300C, 32'hC000_3008, 32'h3008);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3008, 32'hC000_3004, 32'h3004);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h300C, 32'hC000_3008, 32'h3008);
        add(O, O, O, 5'd1, O, 16'hFFFF, 26'h0,     32'h0,        32'h3010, 32'hC000_300C, 32'h300C);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd2, O, 16'h0000, 26'h0C10,  32'h0,        32'h3040, 32'hC000_3004, 32'h3004);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3044, 32'hC000_3040, 32'h3040);
        add(O, O, O, 5'd3, O, 16'h0000, 26'h0,     32'h3008,     32'h3008, 32'hC000_3044, 32'h3044);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h300C, 32'hC000_3008, 32'h3008);
        add(I, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, I, O, 5'd3, O, 16'h0000, 26'h0,     32'h3020,     32'h3004, 32'hC000_3000, 32'h3000);
        add(O, I, O, 5'd3, O, 16'h0000, 26'h0,     32'h3020,     32'h3004, 32'hC000_3000, 32'h3000);
        add(O, I, O, 5'd3, O, 16'h0000, 26'h0,     32'h3020,     32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd3, O, 16'h0000, 26'h0,     32'h3020,     32'h3020, 32'hC000_3004, 32'h3004);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3024, 32'hC000_3020, 32'h3020);
        add(O, I, I, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3024, 32'hC000_3020, 32'h3020);
        add(O, O, I, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3028, 32'h0,        32'h3024);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h302C, 32'hC000_3028, 32'h3028);
        add(I, O, O, 5'd1, I, 16'h0010, 26'h0,     32'h0,        32'h3000, 32'h0,        32'h3000);
        add(O, O, O, 5'd0, O, 16'h0000, 26'h0,     32'h0,        32'h3004, 32'hC000_3000, 32'h3000);
        add(O, O, O, 5'd5, I, 16'h0010, 26'h0C10,  32'h0,        32'h3008, 32'hC000_3004, 32'h3004);

        #1;
        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].s, tbl[k].c, tbl[k].op, tbl[k].cmp, tbl[k].i16, tbl[k].i26, tbl[k].rs);
            cyc();
            chk($sformatf("vec%0d F_pc", k),    bus.F_pc,    tbl[k].f);
            chk($sformatf("vec%0d im_addr", k), bus.im_addr, tbl[k].f);
            chk($sformatf("vec%0d D_instr", k), bus.D_instr, tbl[k].di);
            chk($sformatf("vec%0d D_pc", k),    bus.D_pc,    tbl[k].dp);
        end

`ifdef FETCH_ADDR_CHECK_EN
        drive(I, O, O, 5'd0, O, 16'h0, 26'h0, 32'h0);
        cyc();
        chk("flt reset fault_pc", bus.fault_pc, 32'h0);
        chk("flt reset F_adel", 32'(bus.F_adel), 32'h0);
        drive(O, O, O, 5'd0, O, 16'h0, 26'h0, 32'h0);
        cyc();
        drive(O, O, O, 5'd3, O, 16'h0, 26'h0, 32'h3002);
        cyc();
        chk("flt F_pc 3002", bus.F_pc, 32'h3002);
        chk("flt F_adel at 3002", 32'(bus.F_adel), 32'h1);
        chk("flt fault_pc before", bus.fault_pc, 32'h0);
        drive(O, O, O, 5'd0, O, 16'h0, 26'h0, 32'h0);
        cyc();
        chk("flt D_instr 3002", bus.D_instr, 32'h0);
        chk("flt D_pc 3002", bus.D_pc, 32'h3002);
        chk("flt fault_pc 3002", bus.fault_pc, 32'h3002);
        drive(O, O, O, 5'd3, O, 16'h0, 26'h0, 32'h0);
        cyc();
        chk("flt F_pc 0", bus.F_pc, 32'h0);
        chk("flt F_adel at 0", 32'(bus.F_adel), 32'h1);
        drive(O, O, O, 5'd0, O, 16'h0, 26'h0, 32'h0);
        cyc();
        chk("flt D_instr 0", bus.D_instr, 32'h0);
        chk("flt fault_pc sticky", bus.fault_pc, 32'h3002);
`endif

        for (int i = 0; i < IM_DEPTH; i++) mem[i] = $urandom;
        for (int k = 0; k < 3000; k++) begin
            logic        r, s, c, cmp;
            logic [4:0]  op;
            logic [25:0] i26;
            logic [31:0] rs;
            r   = (k == 0) || ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 7) == 0);
            op  = 5'($urandom_range(0, 7));
            cmp = 1'($urandom_range(0, 1));
            i26 = ($urandom_range(0, 3) == 0) ? 26'($urandom)
                                              : 26'((IM_BASE >> 2) + 32'($urandom_range(0, IM_DEPTH - 1)));
            rs  = ($urandom_range(0, 3) == 0) ? $urandom
                                              : IM_BASE + 32'(4 * $urandom_range(0, IM_DEPTH - 1));
            drive(r, s, c, op, cmp, 16'($urandom), i26, rs);
            model_step();
            cyc();
            chk("rnd F_pc", bus.F_pc, m_f);
            chk("rnd D_instr", bus.D_instr, m_di);
            chk("rnd D_pc", bus.D_pc, m_dp);
`ifdef FETCH_ADDR_CHECK_EN
            chk("rnd F_adel", 32'(bus.F_adel), 32'(addr_bad(m_f)));
            chk("rnd fault_pc", bus.fault_pc, m_fpc);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
